// File: rtl/crc_pkg.sv
// Shared widths and lane placement for the CRC byte packer.
// Lane 0 is the first byte of a word; its bit position depends on byte order.
package crc_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  typedef logic [$clog2(WORD_W)-1:0] lane_off_t;

  function automatic lane_off_t lane_offset(input logic [1:0] idx, input bit big_endian);
    if (big_endian)
      return lane_off_t'((LANES - 1 - int'(idx)) * BYTE_W);
    else
      return lane_off_t'(int'(idx) * BYTE_W);
  endfunction

endpackage

// File: rtl/crc_byte_packer.sv
// Packs a framed valid/ready byte stream into 32-bit en/din beats for the CRC stage,
// padding short final words and reporting byte and word counts with the last word.
module crc_byte_packer
  import crc_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE   = 8'h00,
  parameter bit         BIG_ENDIAN = 1'b1,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             o_ready,
  output logic             en,
  output logic [31:0]      din,
  output logic             din_last,
  output logic [2:0]       din_bytes,
  output logic [CNT_W-1:0] frame_words,
  output logic             ovf
);

  localparam logic [WORD_W-1:0] PAD_WORD = {LANES{PAD_BYTE}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [1:0]        idx_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [WORD_W-1:0] acc_reg;
  logic              en_reg;
  logic [WORD_W-1:0] din_reg;
  logic              din_last_reg;
  logic [2:0]        din_bytes_reg;
  logic [CNT_W-1:0]  frame_words_reg;
  logic              ovf_reg;

  logic              accept;
  logic              complete;
  logic              cnt_sat;
  logic [WORD_W-1:0] word_next;
  logic [CNT_W-1:0]  cnt_next;

  assign s_ready  = !en_reg || o_ready;
  assign accept   = s_valid && s_ready;
  assign complete = accept && ((idx_reg == 2'd3) || s_last);
  assign cnt_sat  = (word_cnt_reg == CNT_MAX);
  assign cnt_next = cnt_sat ? word_cnt_reg : word_cnt_reg + CNT_W'(1);

  // Lanes below idx come from the accumulator, lanes above it are padding, so the
  // accumulator's unwritten lanes never leak into din even straight out of reset.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    localparam lane_off_t  OFF  = lane_offset(LANE, BIG_ENDIAN);
    assign word_next[OFF +: BYTE_W] = (LANE < idx_reg)  ? acc_reg[OFF +: BYTE_W] :
                                      (LANE == idx_reg) ? s_data : PAD_BYTE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      word_cnt_reg    <= '0;
      acc_reg         <= '0;
      en_reg          <= 1'b0;
      din_reg         <= '0;
      din_last_reg    <= 1'b0;
      din_bytes_reg   <= '0;
      frame_words_reg <= '0;
      ovf_reg         <= 1'b0;
    end else begin
      if (complete) begin
        en_reg          <= 1'b1;
        din_reg         <= word_next;
        din_last_reg    <= s_last;
        din_bytes_reg   <= {1'b0, idx_reg} + 3'd1;
        frame_words_reg <= cnt_next;
        acc_reg         <= PAD_WORD;
        idx_reg         <= '0;
        word_cnt_reg    <= s_last ? '0 : cnt_next;
        if (cnt_sat)
          ovf_reg <= 1'b1;
      end else begin
        if (o_ready)
          en_reg <= 1'b0;
        if (accept) begin
          acc_reg <= word_next;
          idx_reg <= idx_reg + 2'd1;
        end
      end
    end
  end

  assign en          = en_reg;
  assign din         = din_reg;
  assign din_last    = din_last_reg;
  assign din_bytes   = din_bytes_reg;
  assign frame_words = frame_words_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_crc_byte_packer.sv
// Bench for crc_byte_packer: three parameterisations share one stimulus stream and
// are checked every cycle against a word-level model, plus literal spot checks.
module tb_crc_byte_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       o_ready;

  logic        en_w[3];
  logic        s_ready_w[3];
  logic        din_last_w[3];
  logic        ovf_w[3];
  logic [31:0] din_w[3];
  logic [2:0]  bytes_w[3];
  logic [15:0] fw_w[3];
  logic [15:0] fw0, fw1;
  logic [1:0]  fw2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // c0: PAD AA, big endian, 16-bit counter
  crc_byte_packer #(.PAD_BYTE(8'hAA), .BIG_ENDIAN(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[0]), .s_data(s_data),
    .s_last(s_last), .o_ready(o_ready), .en(en_w[0]), .din(din_w[0]), .din_last(din_last_w[0]),
    .din_bytes(bytes_w[0]), .frame_words(fw0), .ovf(ovf_w[0]));
  // c1: PAD 00, little endian, 16-bit counter
  crc_byte_packer #(.PAD_BYTE(8'h00), .BIG_ENDIAN(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[1]), .s_data(s_data),
    .s_last(s_last), .o_ready(o_ready), .en(en_w[1]), .din(din_w[1]), .din_last(din_last_w[1]),
    .din_bytes(bytes_w[1]), .frame_words(fw1), .ovf(ovf_w[1]));
  // c2: PAD 00, big endian, 2-bit counter
  crc_byte_packer #(.PAD_BYTE(8'h00), .BIG_ENDIAN(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[2]), .s_data(s_data),
    .s_last(s_last), .o_ready(o_ready), .en(en_w[2]), .din(din_w[2]), .din_last(din_last_w[2]),
    .din_bytes(bytes_w[2]), .frame_words(fw2), .ovf(ovf_w[2]));

  assign fw_w[0] = fw0;
  assign fw_w[1] = fw1;
  assign fw_w[2] = {14'd0, fw2};

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[c%0d] actual=%h required=%h at %0t", name, c, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  cur_q[$];
  logic        m_en;
  logic        m_last;
  int          m_bytes;
  logic [31:0] m_word[3];
  int          m_fw[3];
  int          m_cnt[3];
  logic        m_ovf[3];

  function automatic logic [7:0] pad_of(input int c);
    return (c == 0) ? 8'hAA : 8'h00;
  endfunction

  function automatic int max_of(input int c);
    return (c == 2) ? 3 : 65535;
  endfunction

  // First byte of the frame ends up most significant (big endian) or least significant.
  function automatic logic [31:0] pack(input int c);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = (k < cur_q.size()) ? cur_q[k] : pad_of(c);
      if (c != 1) w = (w << 8) | 32'(b);
      else        w = w | (32'(b) << (8 * k));
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 1'b0; m_last = 1'b0; m_bytes = 0;
      cur_q.delete();
      for (int c = 0; c < 3; c++) begin
        m_word[c] = '0; m_fw[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
      end
    end else if (s_valid && (!m_en || o_ready)) begin
      cur_q.push_back(s_data);
      if (cur_q.size() == 4 || s_last) begin
        for (int c = 0; c < 3; c++) begin
          m_word[c] = pack(c);
          if (m_cnt[c] == max_of(c)) m_ovf[c] = 1'b1;
          else                       m_cnt[c] = m_cnt[c] + 1;
          m_fw[c] = m_cnt[c];
          if (s_last) m_cnt[c] = 0;
        end
        m_bytes = cur_q.size();
        m_last  = s_last;
        m_en    = 1'b1;
        cur_q.delete();
      end else if (o_ready) begin
        m_en = 1'b0;
      end
    end else if (o_ready) begin
      m_en = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk("en", c, 32'(en_w[c]), 32'(m_en));
      chk("s_ready", c, 32'(s_ready_w[c]), 32'(!m_en || o_ready));
      chk("ovf", c, 32'(ovf_w[c]), 32'(m_ovf[c]));
      if (m_en) begin
        chk("din", c, din_w[c], m_word[c]);
        chk("din_last", c, 32'(din_last_w[c]), 32'(m_last));
        chk("din_bytes", c, 32'(bytes_w[c]), 32'(m_bytes));
        if (m_last) chk("frame_words", c, 32'(fw_w[c]), 32'(m_fw[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Returns 1ns after the edge that accepted the byte; s_valid drops unless the caller sends again.
  task automatic send(input logic [7:0] d, input logic l);
    logic taken;
    int   n;
    s_valid = 1'b1; s_data = d; s_last = l;
    taken = 1'b0; n = 0;
    while (!taken && n < 50) begin
      @(negedge clk); #3;
      taken = s_ready_w[0];
      @(posedge clk); #1;
      n++;
    end
    if (!taken) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=blocked required=accepted data=%h", d);
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 0, 32'(en_w[0]), 32'h0);
    chk("rst_din", 0, din_w[0], 32'h0);
    chk("rst_bytes", 0, 32'(bytes_w[0]), 32'h0);
    chk("rst_fw", 0, 32'(fw_w[0]), 32'h0);
    chk("rst_ovf", 0, 32'(ovf_w[0]), 32'h0);
    chk("rst_s_ready", 0, 32'(s_ready_w[0]), 32'h1);
    rst_n = 1'b1;
    idle(1);

    // Full single-word frame
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    chk("t1_en", 0, 32'(en_w[0]), 32'h1);
    chk("t1_din", 0, din_w[0], 32'h01020304);
    chk("t1_bytes", 0, 32'(bytes_w[0]), 32'd4);
    chk("t1_last", 0, 32'(din_last_w[0]), 32'h1);
    chk("t1_fw", 0, 32'(fw_w[0]), 32'd1);
    idle(2);

    // Six-byte frame with padded tail
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk("t2_w1", 0, din_w[0], 32'h01020304);
    chk("t2_w1_last", 0, 32'(din_last_w[0]), 32'h0);
    send(8'h05, 0); send(8'h06, 1);
    chk("t2_w2", 0, din_w[0], 32'h0506AAAA);
    chk("t2_bytes", 0, 32'(bytes_w[0]), 32'd2);
    chk("t2_last", 0, 32'(din_last_w[0]), 32'h1);
    chk("t2_fw", 0, 32'(fw_w[0]), 32'd2);
    idle(2);

    // Little-endian packing
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    chk("t3_le", 1, din_w[1], 32'h44332211);
    idle(1);

    // One-byte frame
    send(8'h77, 1);
    chk("t7_din", 0, din_w[0], 32'h77AAAAAA);
    chk("t7_bytes", 0, 32'(bytes_w[0]), 32'd1);
    chk("t7_fw", 0, 32'(fw_w[0]), 32'd1);

    // Gap in the middle of a word
    send(8'h21, 0); send(8'h22, 0);
    idle(5);
    send(8'h23, 1);
    chk("t8_din", 0, din_w[0], 32'h212223AA);
    chk("t8_bytes", 0, 32'(bytes_w[0]), 32'd3);
    idle(1);

    // Downstream stall right after the first word
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    o_ready = 1'b0;
    fork
      begin
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_stall_s_ready", 0, 32'(s_ready_w[0]), 32'h0);
          chk("t4_stall_din", 0, din_w[0], 32'h01020304);
        end
        #2 o_ready = 1'b1;
      end
    join
    chk("t4_w2", 0, din_w[0], 32'h05060708);
    chk("t4_fw", 0, 32'(fw_w[0]), 32'd2);
    idle(1);

    // Counter saturation on the 2-bit instance
    for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
    chk("t5_fw_sat", 2, 32'(fw_w[2]), 32'd3);
    chk("t5_ovf", 2, 32'(ovf_w[2]), 32'h1);
    chk("t5_fw_wide", 0, 32'(fw_w[0]), 32'd4);
    chk("t5_ovf_wide", 0, 32'(ovf_w[0]), 32'h0);
    idle(1);
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
    chk("t5_ovf_sticky", 2, 32'(ovf_w[2]), 32'h1);
    chk("t5_fw_new", 2, 32'(fw_w[2]), 32'd1);

    // Reset in the middle of a frame
    send(8'h31, 0); send(8'h32, 0);
    rst_n = 1'b0;
    idle(2);
    chk("t6_rst_ovf", 2, 32'(ovf_w[2]), 32'h0);
    rst_n = 1'b1;
    idle(1);
    send(8'h09, 0); send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 1);
    chk("t6_din", 0, din_w[0], 32'h090A0B0C);
    chk("t6_fw", 0, 32'(fw_w[0]), 32'd1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
